uart_rx_fifo: RTL and testbench

// - UART receiver front end for the bios command FSM. Sits directly upstream of bios.
// - Deserialises the async rx line (8 data bits, LSB first, 1 stop bit).
// - Buffers received bytes in a small FIFO.
// - Presents bytes on an AXI-stream-style byte port: o_data/o_valid/i_ready.

---
 rtl/uart_rx_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a byte FIFO with a valid/ready port
`timescale 1ns/1ps

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_frame_err,
    output logic                          o_parity_err,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    logic          rx_meta_q, rx_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push_req;
    logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if ((^shreg_q) ^ par_q) begin
                        parity_err_d = 1'b1;
                        state_d      = S_IDLE;
`endif
                    end else begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                // Only a returning-high line re-arms start detection.
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shreg_q     <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= i_rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          full, valid, pop, push;

    assign full  = (count_q == FULL_CNT);
    assign valid = (count_q != '0);
    assign pop   = valid & i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= shreg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req & full & ~pop) overflow_q <= 1'b1;
        end
    end

    assign o_valid     = valid;
    assign o_data      = valid ? mem_q[rd_ptr_q] : 8'h00;
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, i_rx, i_ready;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_parity_err, o_overflow;
    logic [2:0] o_count;

    int         total = 0;
    int         bad   = 0;
    int         beats = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         fe0, pe0;
    logic [7:0] exp_q [$];
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] want;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_overflow   (o_overflow),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        i_rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
        i_rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (o_frame_err)  fe_cnt++;
            if (o_parity_err) pe_cnt++;
            if (hold_prev) check("hold_data", o_data, hold_data);
            if (o_valid && i_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("extra_beat", o_data, 32'h100);
                end else begin
                    want = exp_q.pop_front();
                    check("beat_data", o_data, want);
                end
            end
            hold_prev = o_valid && !i_ready;
            hold_data = o_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_rx = 1'b1; i_ready = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_data",   o_data, 0);
        check("rst_valid",  o_valid, 0);
        check("rst_fe",     o_frame_err, 0);
        check("rst_pe",     o_parity_err, 0);
        check("rst_ovf",    o_overflow, 0);
        check("rst_count",  o_count, 0);
        tick(1);
        rst = 1'b0;
        tick(2);

        i_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5);
        tick(4 * CPB);
        check("a5_drained", exp_q.size(), 0);
        check("a5_beats",   beats, 1);
        check("a5_count",   o_count, 0);
        check("a5_fe",      fe_cnt, 0);
        check("a5_pe",      pe_cnt, 0);

        i_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            if (v <= DEPTH) exp_q.push_back(8'(v));
            send_byte(8'(v));
        end
        tick(2 * CPB);
        check("ovf_count",  o_count, 4);
        check("ovf_flag",   o_overflow, 1);
        check("ovf_valid",  o_valid, 1);
        check("ovf_head",   o_data, 8'h01);
        i_ready = 1'b1;
        tick(DEPTH + 4);
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_beats",   beats, 5);
        check("ovf_empty",   o_count, 0);
        check("ovf_sticky",  o_overflow, 1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("ovf_cleared", o_overflow, 0);

        i_rx = 1'b0;
        tick(1);
        i_rx = 1'b1;
        tick(4 * CPB);
        check("glitch_count", o_count, 0);
        check("glitch_beats", beats, 5);
        check("glitch_fe",    fe_cnt, 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A);
        tick(4 * CPB);
        check("glitch_next", exp_q.size(), 0);

        fe0 = fe_cnt;
        send_frame(8'h3C, ^8'h3C, 1'b0);
        i_rx = 1'b0;
        tick(20 * CPB);
        i_rx = 1'b1;
        tick(2 * CPB);
        check("brk_fe_pulses", fe_cnt - fe0, 1);
        check("brk_count",     o_count, 0);
        check("brk_beats",     beats, 6);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E);
        tick(4 * CPB);
        check("brk_7e", exp_q.size(), 0);

        i_ready = 1'b0;
        send_byte(8'h99);
        tick(2 * CPB);
        check("mid_pre_count", o_count, 1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        tick(2);
        i_rx = 1'b1;
        rst = 1'b0;
        check("mid_valid", o_valid, 0);
        check("mid_data",  o_data, 0);
        check("mid_count", o_count, 0);
        check("mid_fe",    o_frame_err, 0);
        check("mid_ovf",   o_overflow, 0);
        i_ready = 1'b1;
        exp_q.push_back(8'h12);
        send_byte(8'h12);
        tick(4 * CPB);
        check("mid_12", exp_q.size(), 0);
        check("mid_beats", beats, 8);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b0, 1'b1);
        tick(4 * CPB);
        check("par_ok", exp_q.size(), 0);
        pe0 = pe_cnt;
        send_frame(8'h03, 1'b1, 1'b1);
        tick(4 * CPB);
        check("par_bad_pulse", pe_cnt - pe0, 1);
        check("par_bad_count", o_count, 0);
        check("par_beats",     beats, 9);
`else
        pe0 = pe_cnt;
        check("pe_never", pe0, 0);
`endif
        check("fe_total", fe_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
